// File: rtl/uart_rx_shifter_if.sv
// Receive-side bundle between the RX controller/consumers and uart_rx_shifter.
// The master side drives the line and enable; the slave side is the shifter.
interface uart_rx_shifter_if #(
  parameter int DATA_BITS = 8
);
  logic                 Rx;
  logic                 Shift_Show;
  logic                 Flag;
  logic [DATA_BITS-1:0] Data;
  logic                 Rx_Valid;
  logic                 Frame_Err;
  logic                 Parity_Err;

  modport master (
    output Rx, Shift_Show,
    input  Flag, Data, Rx_Valid, Frame_Err, Parity_Err
  );

  modport slave (
    input  Rx, Shift_Show,
    output Flag, Data, Rx_Valid, Frame_Err, Parity_Err
  );
endinterface

// File: rtl/uart_rx_shifter.sv
// UART receive bit-timing and deserialiser: mid-bit sampling, LSB-first assembly, frame/parity status.
// Optional even-parity bit enabled by defining UART_RX_PARITY_EN.
module uart_rx_shifter #(
  parameter int CYCLES_PER_BIT = 5208,
  parameter int DATA_BITS      = 8
) (
  input logic         Clk,
  input logic         Reset,
  uart_rx_shifter_if.slave bus
);
  localparam int CW = $clog2(CYCLES_PER_BIT);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] HALF_M1  = CW'(CYCLES_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1  = CW'(CYCLES_PER_BIT - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
    S_PARITY = 3'd3,
`endif
    S_STOP   = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0] sh_q, sh_d;
  logic                 ss_q, ss_d;
  logic                 arm_q, arm_d;
  logic                 flag_q, flag_d;
  logic                 valid_q, valid_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 ferr_q, ferr_d;
`ifdef UART_RX_PARITY_EN
  logic                 par_bad_q, par_bad_d;
  logic                 perr_q, perr_d;
`endif

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      sh_q      <= '0;
      ss_q      <= 1'b0;
      arm_q     <= 1'b0;
      flag_q    <= 1'b0;
      valid_q   <= 1'b0;
      data_q    <= '0;
      ferr_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_q <= 1'b0;
      perr_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      sh_q      <= sh_d;
      ss_q      <= ss_d;
      arm_q     <= arm_d;
      flag_q    <= flag_d;
      valid_q   <= valid_d;
      data_q    <= data_d;
      ferr_q    <= ferr_d;
`ifdef UART_RX_PARITY_EN
      par_bad_q <= par_bad_d;
      perr_q    <= perr_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    bit_d   = bit_q;
    sh_d    = sh_q;
    ss_d    = bus.Shift_Show;
    // An enable already high when coming out of reset is not a rising edge.
    arm_d   = arm_q | ~bus.Shift_Show;
    valid_d = 1'b0;
    data_d  = data_q;
    ferr_d  = ferr_q;
`ifdef UART_RX_PARITY_EN
    par_bad_d = par_bad_q;
    perr_d    = perr_q;
`endif
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        bit_d = '0;
        sh_d  = '0;
        if (bus.Shift_Show && !ss_q && arm_q) state_d = S_START;
      end
      S_START: begin
        if (!bus.Shift_Show) begin
          state_d = S_IDLE;
        end else if (cnt_q == HALF_M1) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = bus.Rx ? S_DONE : S_DATA;
        end
      end
      S_DATA: begin
        if (!bus.Shift_Show) begin
          state_d = S_IDLE;
        end else if (cnt_q == FULL_M1) begin
          cnt_d = '0;
          sh_d  = {bus.Rx, sh_q[DATA_BITS-1:1]};
          if (bit_q == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            bit_d = bit_q + BW'(1);
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (!bus.Shift_Show) begin
          state_d = S_IDLE;
        end else if (cnt_q == FULL_M1) begin
          cnt_d     = '0;
          par_bad_d = ^{sh_q, bus.Rx};
          state_d   = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (!bus.Shift_Show) begin
          state_d = S_IDLE;
        end else if (cnt_q == FULL_M1) begin
          cnt_d   = '0;
          state_d = S_DONE;
          ferr_d  = ~bus.Rx;
          if (bus.Rx) begin
            data_d  = sh_q;
            valid_d = 1'b1;
          end
`ifdef UART_RX_PARITY_EN
          perr_d = par_bad_q;
`endif
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    flag_d = (state_d == S_DONE);
  end

  always_comb begin
    bus.Flag      = flag_q;
    bus.Rx_Valid  = valid_q;
    bus.Data      = data_q;
    bus.Frame_Err = ferr_q;
`ifdef UART_RX_PARITY_EN
    bus.Parity_Err = perr_q;
`else
    bus.Parity_Err = 1'b0;
`endif
  end
endmodule
